// File: rtl/dm_cache_pkg.sv
// cache_types: shared definitions for the direct-mapped cache.
//   - cache_state_t : controller states
//   - OFFSET_W / LINE_W / WSEL_W : line geometry (32-byte line, 8 words)
//   - ADDR_* / DATA_* : encodings of the controller's mux selects
//   - tag_width()   : tag bits left over once index and offset are removed
package cache_types;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

    localparam int OFFSET_W = 5;
    localparam int LINE_W   = 256;
    localparam int WSEL_W   = 3;

    // pmem_address source: the requested line, or the line currently resident
    localparam logic ADDR_REQ    = 1'b0;
    localparam logic ADDR_VICTIM = 1'b1;

    // line write source: core write merged into the line, or a fill from pmem
    localparam logic DATA_MERGE = 1'b0;
    localparam logic DATA_FILL  = 1'b1;

    function automatic int tag_width(input int s_index);
        return 32 - OFFSET_W - s_index;
    endfunction

endpackage

// File: rtl/dm_cache_control.sv
// cache_control: sequencing FSM for dm_cache.
//   Inputs : clk, rst (sync, active-high), i_read/i_write (core request),
//            i_hit/i_dirty (lookup of the addressed set), i_pmem_resp.
//   Outputs: o_mem_resp, o_pmem_read, o_pmem_write and the storage strobes
//            o_load_data, o_load_tag, o_set_valid, o_set_dirty, o_clr_dirty,
//            plus mux selects o_addr_sel, o_data_sel.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CHECK     | idle / lookup; hits complete here in the request cycle
// WRITEBACK | dirty victim being written to pmem, held until pmem_resp
// ALLOCATE  | requested line being filled from pmem, held until pmem_resp
module cache_control
    import cache_types::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_read,
    input  logic i_write,
    input  logic i_hit,
    input  logic i_dirty,
    input  logic i_pmem_resp,
    output logic o_mem_resp,
    output logic o_pmem_read,
    output logic o_pmem_write,
    output logic o_load_data,
    output logic o_load_tag,
    output logic o_set_valid,
    output logic o_set_dirty,
    output logic o_clr_dirty,
    output logic o_addr_sel,
    output logic o_data_sel
);

    cache_state_t r_state;
    cache_state_t w_next;

    always_ff @(posedge clk) begin
        if (rst) r_state <= CHECK;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        o_mem_resp   = 1'b0;
        o_pmem_read  = 1'b0;
        o_pmem_write = 1'b0;
        o_load_data  = 1'b0;
        o_load_tag   = 1'b0;
        o_set_valid  = 1'b0;
        o_set_dirty  = 1'b0;
        o_clr_dirty  = 1'b0;
        o_addr_sel   = ADDR_REQ;
        o_data_sel   = DATA_MERGE;
        case (r_state)
            CHECK: begin
                if (i_read || i_write) begin
                    if (i_hit) begin
                        o_mem_resp = 1'b1;
                        // read+write together behaves as a write
                        if (i_write) begin
                            o_load_data = 1'b1;
                            o_set_dirty = 1'b1;
                        end
                    end else begin
                        w_next = i_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                o_pmem_write = 1'b1;
                o_addr_sel   = ADDR_VICTIM;
                if (i_pmem_resp) w_next = ALLOCATE;
            end
            ALLOCATE: begin
                o_pmem_read = 1'b1;
                if (i_pmem_resp) begin
                    o_load_data = 1'b1;
                    o_load_tag  = 1'b1;
                    o_set_valid = 1'b1;
                    o_clr_dirty = 1'b1;
                    o_data_sel  = DATA_FILL;
                    w_next      = CHECK;
                end
            end
            default: w_next = CHECK;
        endcase
    end

endmodule

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-back, write-allocate cache between a
// word-wide core port and a 256-bit line-wide physical memory port.
//   Core side : mem_address, mem_read, mem_write, mem_wmask, mem_wdata in;
//               mem_rdata, mem_resp out (hit completes in the request cycle).
//   Pmem side : pmem_address, pmem_read, pmem_write, pmem_wdata out;
//               pmem_rdata, pmem_resp in (level-held request/response).
//   clk, rst  : rst synchronous, active-high.
// Holds the per-set valid/dirty/tag/data arrays, the masked-word merge and
// the pmem address mux; sequencing lives in cache_control.
module dm_cache
    import cache_types::*;
#(
    parameter int S_INDEX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_resp,
    output logic [31:0]       pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = tag_width(S_INDEX);

    logic [SETS-1:0]    r_valid;
    logic [SETS-1:0]    r_dirty;
    logic [TAG_W-1:0]   r_tag  [SETS];
    logic [LINE_W-1:0]  r_data [SETS];

    logic [TAG_W-1:0]   w_req_tag;
    logic [S_INDEX-1:0] w_idx;
    logic [WSEL_W-1:0]  w_wsel;
    logic [1:0]         w_unused_addr;
    logic               w_hit;
    logic               w_mem_resp;
    logic               w_load_data, w_load_tag, w_set_valid;
    logic               w_set_dirty, w_clr_dirty, w_addr_sel, w_data_sel;
    logic [31:0]        w_old_word, w_new_word;
    logic [LINE_W-1:0]  w_merged_line, w_line_in;
    logic [31:0]        w_pmem_addr;

    assign w_req_tag     = mem_address[31 -: TAG_W];
    assign w_idx         = mem_address[OFFSET_W +: S_INDEX];
    assign w_wsel        = mem_address[4:2];
    assign w_unused_addr = mem_address[1:0];

    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_req_tag);

    cache_control u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_read       (mem_read),
        .i_write      (mem_write),
        .i_hit        (w_hit),
        .i_dirty      (r_dirty[w_idx]),
        .i_pmem_resp  (pmem_resp),
        .o_mem_resp   (w_mem_resp),
        .o_pmem_read  (pmem_read),
        .o_pmem_write (pmem_write),
        .o_load_data  (w_load_data),
        .o_load_tag   (w_load_tag),
        .o_set_valid  (w_set_valid),
        .o_set_dirty  (w_set_dirty),
        .o_clr_dirty  (w_clr_dirty),
        .o_addr_sel   (w_addr_sel),
        .o_data_sel   (w_data_sel)
    );

    always_comb begin
        w_old_word = r_data[w_idx][{w_wsel, 5'b0} +: 32];
        w_new_word = w_old_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b]) w_new_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
        end
        w_merged_line = r_data[w_idx];
        w_merged_line[{w_wsel, 5'b0} +: 32] = w_new_word;
    end

    assign w_line_in = (w_data_sel == DATA_FILL) ? pmem_rdata : w_merged_line;

    // Storage writes are suppressed in a reset cycle so reset wins over a
    // same-cycle hit write; tag/data themselves carry no reset value.
    always_ff @(posedge clk) begin
        if (w_load_data && !rst) r_data[w_idx] <= w_line_in;
        if (w_load_tag && !rst)  r_tag[w_idx]  <= w_req_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (w_set_valid) r_valid[w_idx] <= 1'b1;
            if (w_set_dirty)      r_dirty[w_idx] <= 1'b1;
            else if (w_clr_dirty) r_dirty[w_idx] <= 1'b0;
        end
    end

    assign w_pmem_addr = (w_addr_sel == ADDR_VICTIM) ? {r_tag[w_idx], w_idx, 5'b0}
                                                     : {w_req_tag, w_idx, 5'b0};

    // Address reads as zero whenever no line transfer is in progress.
    assign pmem_address = (pmem_read || pmem_write) ? w_pmem_addr : 32'd0;
    assign pmem_wdata   = r_data[w_idx];
    assign mem_rdata    = w_old_word;
    assign mem_resp     = w_mem_resp && !rst;

endmodule
